// File: rtl/cache_types_pkg.sv
// Shared types and sizing constants for the cache line <-> memory burst adapter.
package cache_types_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_BEAT,
        WR_BEAT,
        DONE
    } state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts single cache-line fill/write-back requests into 4-beat memory bursts
// and reassembles read beats into a full line for the cache.
module cacheline_adapter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = cache_types_pkg::LINE_W,
    parameter int BURST_W = cache_types_pkg::BURST_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LINE_W-1:0]       line_i,
    output logic [LINE_W-1:0]       line_o,
    input  logic [ADDR_W-1:0]       address_i,
    input  logic                    read_i,
    input  logic                    write_i,
    output logic                    resp_o,
    input  logic [BURST_W-1:0]      burst_i,
    output logic [BURST_W-1:0]      burst_o,
    output logic [ADDR_W-1:0]       address_o,
    output logic                    read_o,
    output logic                    write_o,
    input  logic                    resp_i,
    output cache_types_pkg::state_e state
);

    // Handshake: read_o/write_o act as a request held for the whole burst; every
    // cycle resp_i=1 while a request is up transfers exactly one beat, resp_i=0
    // stalls with nothing consumed, and resp_i outside a burst is ignored.

    localparam int               OFFSET_W  = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);
    localparam logic [1:0]       LAST_BEAT = 2'(cache_types_pkg::BEATS - 1);

    cache_types_pkg::state_e state_q, state_d;
    logic [1:0]              cnt_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LINE_W-1:0]       line_q;
    logic [LINE_W-1:0]       wdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            cache_types_pkg::IDLE: begin
                if (write_i)     state_d = cache_types_pkg::WR_BEAT;
                else if (read_i) state_d = cache_types_pkg::RD_REQ;
            end
            cache_types_pkg::RD_REQ:
                if (resp_i) state_d = cache_types_pkg::RD_BEAT;
            cache_types_pkg::RD_BEAT:
                if (resp_i && cnt_q == LAST_BEAT) state_d = cache_types_pkg::DONE;
            cache_types_pkg::WR_BEAT:
                if (resp_i && cnt_q == LAST_BEAT) state_d = cache_types_pkg::DONE;
            cache_types_pkg::DONE:
                state_d = cache_types_pkg::IDLE;
            default:
                state_d = cache_types_pkg::IDLE;
        endcase
    end

    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        case (state_q)
            cache_types_pkg::RD_REQ,
            cache_types_pkg::RD_BEAT: read_o  = 1'b1;
            cache_types_pkg::WR_BEAT: write_o = 1'b1;
            cache_types_pkg::DONE:    resp_o  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= cache_types_pkg::IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            line_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                cache_types_pkg::IDLE: begin
                    cnt_q <= 2'd0;
                    if (write_i) begin
                        wdata_q <= line_i;
                        addr_q  <= address_i;
                    end else if (read_i) begin
                        addr_q  <= address_i;
                    end
                end
                cache_types_pkg::RD_REQ: begin
                    if (resp_i) begin
                        line_q[BURST_W-1:0] <= burst_i;
                        cnt_q               <= 2'd1;
                    end
                end
                cache_types_pkg::RD_BEAT: begin
                    if (resp_i) begin
                        line_q[int'(cnt_q)*BURST_W +: BURST_W] <= burst_i;
                        // The last beat leaves the counter parked; IDLE clears it.
                        if (cnt_q != LAST_BEAT) cnt_q <= cnt_q + 2'd1;
                    end
                end
                cache_types_pkg::WR_BEAT: begin
                    if (resp_i && cnt_q != LAST_BEAT) cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign line_o    = line_q;
    assign address_o = addr_q & ADDR_MASK;
    assign burst_o   = wdata_q[int'(cnt_q)*BURST_W +: BURST_W];
    assign state     = state_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: memory-side responder with scoreboarded read lines
// and write beats, stall patterns, request priority, async reset and idle noise.
module tb_cacheline_adapter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [LINE_W-1:0]   line_i = '0;
    logic [LINE_W-1:0]   line_o;
    logic [ADDR_W-1:0]   address_i = '0;
    logic                read_i = 1'b0;
    logic                write_i = 1'b0;
    logic                resp_o;
    logic [BURST_W-1:0]  burst_i = '0;
    logic [BURST_W-1:0]  burst_o;
    logic [ADDR_W-1:0]   address_o;
    logic                read_o;
    logic                write_o;
    logic                resp_i = 1'b0;
    cache_types_pkg::state_e state;

    logic [LINE_W-1:0]  exp_q[$];
    logic [BURST_W-1:0] exp_w_q[$];
    logic [LINE_W-1:0]  last_line;
    int n_cmp = 0;
    int n_fail = 0;

    cacheline_adapter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [BURST_W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {read_o, write_o, resp_o});
        end
        n_cmp++;
        if (state !== cache_types_pkg::IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, cache_types_pkg::IDLE);
        end
        n_cmp++;
        if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
            n_fail++; $display("FAIL reset_data: got line %h burst %h addr %h expected all 0", line_o, burst_o, address_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        last_line = '0;
    endtask

    // pat: bit idx gives resp_i for the idx-th bursting cycle (LSB first).
    task automatic run_read(input logic [ADDR_W-1:0] addr, input logic [3:0][BURST_W-1:0] beats,
                            input logic [15:0] pat, input string name);
        int exp_cyc = 0, ones = 0, cycles = 0, idx = 0, sent = 0;
        bit got = 0;
        for (int i = 0; i < 16 && ones < 4; i++) begin
            if (pat[i]) ones++;
            exp_cyc = i + 1;
        end
        exp_q.push_back(beats);
        @(posedge clk); #1;
        address_i = addr; read_i = 1'b1;
        @(posedge clk); #1;
        read_i = 1'b0; address_i = $urandom;
        while (!got && cycles < 64) begin
            if (sent < 4) begin
                resp_i = (idx < 16) ? pat[idx] : 1'b1;
                idx++;
            end else begin
                resp_i = 1'b0;
            end
            burst_i = resp_i ? beats[sent] : rand64();
            @(negedge clk);
            if (resp_o === 1'b1) begin
                got = 1;
                n_cmp++;
                if (cycles !== exp_cyc) begin
                    n_fail++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, cycles, exp_cyc);
                end
                n_cmp++;
                if (line_o !== exp_q[0]) begin
                    n_fail++; $display("FAIL %s_line: got %h expected %h", name, line_o, exp_q[0]);
                end
                n_cmp++;
                if (read_o !== 1'b0 || write_o !== 1'b0) begin
                    n_fail++; $display("FAIL %s_done_req: got rd %b wr %b expected 0 0", name, read_o, write_o);
                end
                last_line = exp_q.pop_front();
            end else begin
                n_cmp++;
                if (read_o !== 1'b1 || write_o !== 1'b0) begin
                    n_fail++; $display("FAIL %s_read_o: got rd %b wr %b expected 1 0 at cycle %0d", name, read_o, write_o, cycles);
                end
                n_cmp++;
                if (address_o !== (addr & ~32'h1F)) begin
                    n_fail++; $display("FAIL %s_addr: got %h expected %h", name, address_o, addr & ~32'h1F);
                end
                @(posedge clk); #1;
                if (resp_i) sent++;
                cycles++;
            end
        end
        resp_i = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no resp_o expected resp_o within 64 cycles", name);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (resp_o !== 1'b0 || state !== cache_types_pkg::IDLE) begin
            n_fail++; $display("FAIL %s_one_shot: got resp %b state %0d expected 0 IDLE", name, resp_o, state);
        end
    endtask

    task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                             input logic [15:0] pat, input bit both, input string name);
        int cycles = 0, idx = 0;
        bit got = 0;
        for (int k = 0; k < 4; k++) exp_w_q.push_back(line[k*BURST_W +: BURST_W]);
        @(posedge clk); #1;
        address_i = addr; line_i = line; write_i = 1'b1; read_i = both;
        @(posedge clk); #1;
        write_i = 1'b0; read_i = 1'b0; line_i = {4{rand64()}};
        while (!got && cycles < 64) begin
            resp_i = (exp_w_q.size() == 0) ? 1'b0 : ((idx < 16) ? pat[idx] : 1'b1);
            idx++;
            burst_i = rand64();
            @(negedge clk);
            if (resp_o === 1'b1) begin
                got = 1;
                n_cmp++;
                if (exp_w_q.size() != 0) begin
                    n_fail++; $display("FAIL %s_early_done: got resp_o with %0d beats left expected 0", name, exp_w_q.size());
                end
                n_cmp++;
                if (write_o !== 1'b0 || read_o !== 1'b0) begin
                    n_fail++; $display("FAIL %s_done_req: got rd %b wr %b expected 0 0", name, read_o, write_o);
                end
                n_cmp++;
                if (line_o !== last_line) begin
                    n_fail++; $display("FAIL %s_line_hold: got %h expected %h", name, line_o, last_line);
                end
            end else begin
                n_cmp++;
                if (write_o !== 1'b1 || read_o !== 1'b0) begin
                    n_fail++; $display("FAIL %s_write_o: got rd %b wr %b expected 0 1 at cycle %0d", name, read_o, write_o, cycles);
                end
                if (exp_w_q.size() != 0) begin
                    n_cmp++;
                    if (burst_o !== exp_w_q[0]) begin
                        n_fail++; $display("FAIL %s_beat: got %h expected %h", name, burst_o, exp_w_q[0]);
                    end
                end
                n_cmp++;
                if (address_o !== (addr & ~32'h1F)) begin
                    n_fail++; $display("FAIL %s_addr: got %h expected %h", name, address_o, addr & ~32'h1F);
                end
                @(posedge clk); #1;
                if (resp_i && exp_w_q.size() != 0) void'(exp_w_q.pop_front());
                cycles++;
            end
        end
        resp_i = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no resp_o expected resp_o within 64 cycles", name);
        end
        exp_w_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (resp_o !== 1'b0 || state !== cache_types_pkg::IDLE) begin
            n_fail++; $display("FAIL %s_one_shot: got resp %b state %0d expected 0 IDLE", name, resp_o, state);
        end
    endtask

    task automatic test_read_basic();
        run_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                 16'hFFFF, "read");
    endtask

    task automatic test_write_basic();
        run_write(32'h0000_5678, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                  16'hFFFF, 1'b0, "write");
    endtask

    task automatic test_stalled_read();
        run_read(32'hABCD_EF17, {rand64(), rand64(), rand64(), rand64()}, 16'b1011001, "stall_read");
    endtask

    task automatic test_stalled_write();
        run_write(32'h0000_0040, {rand64(), rand64(), rand64(), rand64()}, 16'b0110_1001, 1'b0, "stall_write");
    endtask

    task automatic test_priority();
        run_write(32'h1000_003F, {rand64(), rand64(), rand64(), rand64()}, 16'hFFFF, 1'b1, "priority");
    endtask

    task automatic test_idle_resp();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            resp_i = 1'b1; burst_i = rand64();
            @(negedge clk);
            n_cmp++;
            if (state !== cache_types_pkg::IDLE || resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
                n_fail++; $display("FAIL idle_resp_ctrl: got state %0d resp %b rd %b wr %b expected IDLE 0 0 0", state, resp_o, read_o, write_o);
            end
            n_cmp++;
            if (line_o !== last_line) begin
                n_fail++; $display("FAIL idle_resp_line: got %h expected %h", line_o, last_line);
            end
        end
        @(posedge clk); #1;
        resp_i = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        address_i = 32'h0000_2000; read_i = 1'b1;
        @(posedge clk); #1;
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            resp_i = 1'b1; burst_i = rand64();
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({read_o, write_o, resp_o} !== 3'b000 || state !== cache_types_pkg::IDLE) begin
            n_fail++; $display("FAIL midreset_ctrl: got rd/wr/resp %b state %0d expected 000 IDLE", {read_o, write_o, resp_o}, state);
        end
        n_cmp++;
        if (line_o !== '0 || address_o !== '0 || burst_o !== '0) begin
            n_fail++; $display("FAIL midreset_data: got line %h addr %h burst %h expected all 0", line_o, address_o, burst_o);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        last_line = '0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (resp_o !== 1'b0 || state !== cache_types_pkg::IDLE) begin
                n_fail++; $display("FAIL midreset_abandon: got resp %b state %0d expected 0 IDLE", resp_o, state);
            end
        end
        run_read(32'h0000_2000, {rand64(), rand64(), rand64(), rand64()}, 16'hFFFF, "post_reset_read");
    endtask

    task automatic test_back_to_back();
        run_read(32'h0000_0100, {rand64(), rand64(), rand64(), rand64()}, 16'b0101_0101, "b2b_read");
        run_write(32'h0000_0200, {rand64(), rand64(), rand64(), rand64()}, 16'hFFFF, 1'b0, "b2b_write");
        run_read(32'hFFFF_FFFF, {rand64(), rand64(), rand64(), rand64()}, 16'hFFFF, "b2b_read2");
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_stalled_read();
        test_stalled_write();
        test_priority();
        test_idle_resp();
        test_reset_mid_read();
        test_back_to_back();
        test_idle_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
